// File: rtl/led_seq_monitor_if.sv
// LED bus and monitor status signals between the sequencer side and the monitor.
// The monitor takes the slave modport; benches and consumers take the master modport.
interface led_seq_monitor_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned LW = $clog2(N + 1);

  logic [N-1:0]     led_in;
  logic [LW-1:0]    level;
  logic             dir;
  logic             locked;
  logic             code_err;
  logic             step_err;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output led_in,
    input  level, dir, locked, code_err, step_err, cycle_cnt
  );

  modport slave (
    input  led_in,
    output level, dir, locked, code_err, step_err, cycle_cnt
  );
endinterface

// File: rtl/led_seq_monitor.sv
// Receive-side checker for the thermometer-coded LED fill/drain bus.
// It synchronises the bus, decodes the fill level, tracks direction, flags faults and counts cycles.
module led_seq_monitor #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rs,
  led_seq_monitor_if.slave   bus
);
  localparam int unsigned LW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SYNC, FILL, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     sync1, sync2, last;
  logic [LW-1:0]    level_q, level_nxt;
  logic             dir_q, dir_nxt;
  logic             locked_q;
  logic             code_err_q, code_err_nxt;
  logic             step_err_q, step_err_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  logic             accept_c, legal_c, up_c, down_c, full_c, empty_c, reacq_c;
  logic [LW-1:0]    code_lvl_c;

  // Decode the synchronised bus: an LSB-justified run of ones has no carry overlap with itself+1.
  always_comb begin
    accept_c   = (sync2 != last);
    legal_c    = ((sync2 & (sync2 + N'(1))) == '0);
    code_lvl_c = '0;
    for (int i = 0; i < N; i++) begin
      code_lvl_c = code_lvl_c + LW'(sync2[i]);
    end
    up_c    = ((LW+1)'(code_lvl_c) == (LW+1)'(level_q) + (LW+1)'(1));
    down_c  = ((LW+1)'(code_lvl_c) + (LW+1)'(1) == (LW+1)'(level_q));
    full_c  = (code_lvl_c == LW'(N));
    empty_c = (code_lvl_c == '0);
  end

  // Next-state and next-output logic; only accepted samples move anything.
  always_comb begin
    state_nxt    = state;
    level_nxt    = level_q;
    dir_nxt      = dir_q;
    code_err_nxt = 1'b0;
    step_err_nxt = 1'b0;
    cnt_nxt      = cnt_q;
    reacq_c      = 1'b0;

    if (accept_c) begin
      if (!legal_c) begin
        code_err_nxt = 1'b1;
        state_nxt    = IDLE;
      end else begin
        level_nxt = code_lvl_c;
        unique case (state)
          IDLE: reacq_c = 1'b1;
          SYNC: begin
            if (up_c) begin
              state_nxt = full_c ? DRAIN : FILL;
              dir_nxt   = !full_c;
            end else if (down_c) begin
              state_nxt = empty_c ? FILL : DRAIN;
              dir_nxt   = empty_c;
            end
          end
          FILL: begin
            if (up_c) begin
              if (full_c) begin
                state_nxt = DRAIN;
                dir_nxt   = 1'b0;
              end
            end else begin
              step_err_nxt = 1'b1;
              reacq_c      = 1'b1;
            end
          end
          DRAIN: begin
            if (down_c) begin
              if (empty_c) begin
                state_nxt = FILL;
                dir_nxt   = 1'b1;
                cnt_nxt   = cnt_q + CNT_W'(1);
              end
            end else begin
              step_err_nxt = 1'b1;
              reacq_c      = 1'b1;
            end
          end
        endcase

        // Re-acquisition: the end stops lock immediately, anything in between needs a step.
        if (reacq_c) begin
          if (empty_c) begin
            state_nxt = FILL;
            dir_nxt   = 1'b1;
          end else if (full_c) begin
            state_nxt = DRAIN;
            dir_nxt   = 1'b0;
          end else begin
            state_nxt = SYNC;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) state <= IDLE;
    else     state <= state_nxt;
  end

  // Two-flop synchroniser, last-accepted register and registered outputs.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      sync1      <= '0;
      sync2      <= '0;
      last       <= '0;
      level_q    <= '0;
      dir_q      <= 1'b0;
      locked_q   <= 1'b0;
      code_err_q <= 1'b0;
      step_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1      <= bus.led_in;
      sync2      <= sync1;
      if (accept_c) last <= sync2;
      level_q    <= level_nxt;
      dir_q      <= dir_nxt;
      locked_q   <= (state_nxt == FILL) || (state_nxt == DRAIN);
      code_err_q <= code_err_nxt;
      step_err_q <= step_err_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

  assign bus.level     = level_q;
  assign bus.dir       = dir_q;
  assign bus.locked    = locked_q;
  assign bus.code_err  = code_err_q;
  assign bus.step_err  = step_err_q;
  assign bus.cycle_cnt = cnt_q;
endmodule

// File: tb/tb_led_seq_monitor.sv
// Randomised self-checking bench for led_seq_monitor against a level/lock reference model.
module tb_led_seq_monitor;
  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rs;
  always #10 clk = ~clk;

  led_seq_monitor_if #(.N(N), .CNT_W(CNT_W)) bus ();

  led_seq_monitor #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rs  (rs),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: fill level, direction, lock and whether a reference level exists.
  int           m_level;
  bit           m_dir, m_locked, m_ref;
  int           m_cnt;
  logic [N-1:0] m_bus;
  bit           e_code, e_step;

  // Sequencer-like stimulus generator.
  int gen_lvl;
  bit gen_dir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] therm(input int l);
    logic [N:0] t;
    t = (N+1)'((1 << l) - 1);
    return t[N-1:0];
  endfunction

  function automatic int code_level(input logic [N-1:0] c);
    for (int l = 0; l <= N; l++) begin
      if (c == therm(l)) return l;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_level = 0; m_dir = 1'b0; m_locked = 1'b0; m_ref = 1'b0;
    m_cnt = 0; m_bus = '0; e_code = 1'b0; e_step = 1'b0;
  endtask

  task automatic model_acquire(input int l);
    m_level  = l;
    m_ref    = 1'b1;
    m_locked = (l == 0) || (l == N);
    if (l == 0)      m_dir = 1'b1;
    else if (l == N) m_dir = 1'b0;
  endtask

  task automatic model_event(input logic [N-1:0] code);
    int l, d;
    e_code = 1'b0;
    e_step = 1'b0;
    l = code_level(code);
    if (l < 0) begin
      e_code   = 1'b1;
      m_locked = 1'b0;
      m_ref    = 1'b0;
    end else if (!m_ref) begin
      model_acquire(l);
    end else begin
      d = l - m_level;
      if (m_locked) begin
        if (d == (m_dir ? 1 : -1)) begin
          if (!m_dir && l == 0) m_cnt = (m_cnt + 1) % (1 << CNT_W);
          m_level = l;
          if (l == N) m_dir = 1'b0;
          if (l == 0) m_dir = 1'b1;
        end else begin
          e_step = 1'b1;
          model_acquire(l);
        end
      end else begin
        m_level = l;
        if (d == 1 || d == -1) begin
          m_locked = 1'b1;
          m_dir    = (d > 0);
          if (l == N) m_dir = 1'b0;
          if (l == 0) m_dir = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".level"},    32'(bus.level),     32'(m_level));
    check({tag, ".dir"},      32'(bus.dir),       32'(m_dir));
    check({tag, ".locked"},   32'(bus.locked),    32'(m_locked));
    check({tag, ".cnt"},      32'(bus.cycle_cnt), 32'(m_cnt));
    check({tag, ".code_err"}, 32'(bus.code_err),  32'(e_code));
    check({tag, ".step_err"}, 32'(bus.step_err),  32'(e_step));
  endtask

  // Drive one bus value for 'hold' cycles (>=4), starting 1 time unit after a rising edge.
  task automatic apply(input logic [N-1:0] code, input int hold);
    int old_level;
    bit ev;
    old_level  = m_level;
    ev         = (code !== m_bus);
    bus.led_in = code;
    m_bus      = code;
    repeat (2) @(posedge clk);
    #1;
    if (ev) begin
      check("latency.level", 32'(bus.level), 32'(old_level));
      check("latency.err",   32'({bus.code_err, bus.step_err}), 32'(0));
    end
    @(posedge clk);
    #1;
    if (ev) begin
      model_event(code);
    end else begin
      e_code = 1'b0;
      e_step = 1'b0;
    end
    check_all("update");
    @(posedge clk);
    #1;
    check("pulse_width", 32'({bus.code_err, bus.step_err}), 32'(0));
    e_code = 1'b0;
    e_step = 1'b0;
    if (hold > 4) begin
      repeat (hold - 4) @(posedge clk);
      #1;
      check("hold.level", 32'(bus.level), 32'(m_level));
      check("hold.err",   32'({bus.code_err, bus.step_err}), 32'(0));
    end
  endtask

  task automatic do_reset();
    rs         = 1'b0;
    bus.led_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rs = 1'b1;
    gen_lvl = 0;
    gen_dir = 1'b1;
  endtask

  task automatic gen_step();
    if (gen_dir) gen_lvl++; else gen_lvl--;
    if (gen_lvl >= N) begin gen_lvl = N; gen_dir = 1'b0; end
    if (gen_lvl <= 0) begin gen_lvl = 0; gen_dir = 1'b1; end
  endtask

  initial begin
    logic [N-1:0] c;
    int r;

    // Full fill then drain, each code held 10 cycles, with a long pause at level 4.
    do_reset();
    for (int l = 0; l <= N; l++) apply(therm(l), (l == 4) ? 200 : 10);
    for (int l = N - 1; l >= 0; l--) apply(therm(l), 10);
    check("sweep.cnt", 32'(bus.cycle_cnt), 32'(1));

    // First code 07 leaves the monitor unlocked, then 0F locks it filling.
    do_reset();
    apply(8'h07, 6);
    check("sync.locked", 32'(bus.locked), 32'(0));
    apply(8'h0F, 6);
    check("fill.locked", 32'(bus.locked), 32'(1));
    check("fill.level",  32'(bus.level),  32'(4));
    check("fill.dir",    32'(bus.dir),    32'(1));

    // Bad step from level 5, recovery, illegal code, recovery at zero.
    apply(8'h1F, 6);
    apply(8'h03, 6);
    check("bad_step.level", 32'(bus.level), 32'(2));
    apply(8'h07, 6);
    apply(8'h05, 6);
    check("bad_code.level", 32'(bus.level), 32'(3));
    apply(8'h00, 6);
    check("recover.locked", 32'(bus.locked), 32'(1));

    // Sequencer reset mid-drain.
    for (int l = 1; l <= N; l++) apply(therm(l), 4);
    apply(therm(N - 1), 4);
    apply(8'h00, 4);
    check("seq_reset.locked", 32'(bus.locked), 32'(1));

    // Randomised mix of legal steps, jumps, illegal codes, zero jumps and holds.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 11);
      if (r <= 6) begin
        gen_step();
        c = therm(gen_lvl);
      end else if (r == 7) begin
        gen_lvl = $urandom_range(0, N);
        c = therm(gen_lvl);
      end else if (r == 8) begin
        c = N'($urandom);
        while (code_level(c) >= 0) c = N'($urandom);
      end else if (r == 9) begin
        gen_lvl = 0;
        gen_dir = 1'b1;
        c = '0;
      end else begin
        c = m_bus;
      end
      apply(c, $urandom_range(4, 8));
    end

    // 256 complete fill-drain cycles wrap the counter.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      for (int l = 1; l <= N; l++) apply(therm(l), 4);
      for (int l = N - 1; l >= 0; l--) apply(therm(l), 4);
    end
    check("wrap.cnt", 32'(bus.cycle_cnt), 32'(0));

    // Asynchronous reset mid-cycle must clear outputs before the next edge.
    apply(8'h01, 4);
    apply(8'h03, 4);
    apply(8'h07, 4);
    @(posedge clk);
    #3;
    rs = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
